// File: rtl/branch_resolve_unit.sv
// Branch resolution: mispredict detection, one-cycle flush/redirect, and a BTB update queue.
// Optional performance counters are compiled in when BRU_PERF_CTR_EN is defined.
module branch_resolve_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic                  ex_taken,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  input  logic                  ex_pred_taken,
  input  logic [ADDR_WIDTH-1:0] ex_pred_target,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  update_valid,
  output logic [ADDR_WIDTH-1:0] update_pc,
  output logic [ADDR_WIDTH-1:0] target_pc,
  input  logic                  update_ready,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count,
  output logic [31:0]           drop_count
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic                  target_wrong;
  logic                  mispredict;
  logic                  enqueue;
  logic [ADDR_WIDTH-1:0] correct_pc;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [ADDR_WIDTH-1:0] fifo_pc  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_tgt [FIFO_DEPTH];
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  push;

  always_comb begin
    target_wrong = ex_taken && ex_pred_taken && (ex_target != ex_pred_target);
    mispredict   = ex_valid && ((ex_taken != ex_pred_taken) || target_wrong);
    enqueue      = ex_valid && ex_taken && (!ex_pred_taken || (ex_target != ex_pred_target));
    correct_pc   = ex_taken ? ex_target : (ex_pc + ADDR_WIDTH'(4));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush <= mispredict;
      if (mispredict) redirect_pc <= correct_pc;
    end
  end

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (pointers equal).
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    pop   = !empty && update_ready;
    push  = enqueue && (!full || pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr[IDX_W-1:0]]  <= ex_pc;
      fifo_tgt[wr_ptr[IDX_W-1:0]] <= ex_target;
    end
  end

  always_comb begin
    update_valid = !empty;
    update_pc    = empty ? '0 : fifo_pc[rd_ptr[IDX_W-1:0]];
    target_pc    = empty ? '0 : fifo_tgt[rd_ptr[IDX_W-1:0]];
  end

`ifdef BRU_PERF_CTR_EN
  logic drop;

  always_comb begin
    drop = enqueue && full && !pop;
  end

  // All counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
      drop_count       <= '0;
    end else begin
      if (ex_valid && (branch_count != 32'hFFFF_FFFF))
        branch_count <= branch_count + 32'd1;
      if (mispredict && (mispredict_count != 32'hFFFF_FFFF))
        mispredict_count <= mispredict_count + 32'd1;
      if (drop && (drop_count != 32'hFFFF_FFFF))
        drop_count <= drop_count + 32'd1;
    end
  end
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
  assign drop_count       = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; counter expectations follow BRU_PERF_CTR_EN.
module tb_branch_resolve_unit;

`ifdef BRU_PERF_CTR_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [31:0] target_pc;
  logic        update_ready;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  logic [31:0] drop_count;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.ADDR_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .update_valid(update_valid), .update_pc(update_pc), .target_pc(target_pc),
    .update_ready(update_ready),
    .branch_count(branch_count), .mispredict_count(mispredict_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ctr(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                       input logic ptk, input logic [31:0] ptg);
    ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
  endtask

  task automatic test_reset();
    rst = 1'b0; update_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #3;
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush got %h exp 0", flush); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_redirect got %h exp 0", redirect_pc); end
    checks++; if (update_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_uvalid got %h exp 0", update_valid); end
    checks++; if (update_pc !== 32'h0 || target_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_head got %h/%h exp 0/0", update_pc, target_pc); end
    checks++; if (branch_count !== 32'h0 || mispredict_count !== 32'h0 || drop_count !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_counters got %h/%h/%h exp 0", branch_count, mispredict_count, drop_count); end
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_taken_mispredict();
    drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    #1;
    checks++; if (update_valid !== 1'b0) begin errors++; $display("[TB] FAIL no_bypass got %h exp 0", update_valid); end
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL t034_flush got %h exp 1", flush); end
    checks++; if (redirect_pc !== 32'h200) begin errors++; $display("[TB] FAIL t034_redirect got %h exp 200", redirect_pc); end
    checks++; if (update_valid !== 1'b1 || update_pc !== 32'h100 || target_pc !== 32'h200) begin
      errors++; $display("[TB] FAIL t034_enqueue got %h %h %h exp 1 100 200", update_valid, update_pc, target_pc); end
    step();
    checks++; if (flush !== 1'b0 || redirect_pc !== 32'h200) begin errors++; $display("[TB] FAIL t034_flush_one_cycle got %h %h exp 0 200", flush, redirect_pc); end
    checks++; if (update_valid !== 1'b1 || update_pc !== 32'h100) begin errors++; $display("[TB] FAIL t034_head_stable got %h %h exp 1 100", update_valid, update_pc); end
    update_ready = 1'b1;
    step();
    update_ready = 1'b0;
    checks++; if (update_valid !== 1'b0 || update_pc !== 32'h0) begin errors++; $display("[TB] FAIL t034_popped got %h %h exp 0 0", update_valid, update_pc); end
  endtask

  task automatic test_not_taken_mispredict();
    drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h400);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h304) begin errors++; $display("[TB] FAIL t035_redirect got %h %h exp 1 304", flush, redirect_pc); end
    checks++; if (update_valid !== 1'b0) begin errors++; $display("[TB] FAIL t035_no_enqueue got %h exp 0", update_valid); end
  endtask

  task automatic test_correct_taken();
    drive(1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 32'h600);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (flush !== 1'b0 || redirect_pc !== 32'h304) begin errors++; $display("[TB] FAIL t036_no_flush got %h %h exp 0 304", flush, redirect_pc); end
    checks++; if (update_valid !== 1'b0) begin errors++; $display("[TB] FAIL t036_no_enqueue got %h exp 0", update_valid); end
    checks++; if (mispredict_count !== ctr(2) || branch_count !== ctr(3)) begin
      errors++; $display("[TB] FAIL t036_counters got %h %h exp %h %h", mispredict_count, branch_count, ctr(2), ctr(3)); end
  endtask

  task automatic test_wrap_and_target();
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
    step();
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h0) begin errors++; $display("[TB] FAIL pc_wrap got %h %h exp 1 0", flush, redirect_pc); end
    drive(1'b1, 32'h700, 1'b1, 32'h800, 1'b1, 32'h900);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h800) begin errors++; $display("[TB] FAIL wrong_target got %h %h exp 1 800", flush, redirect_pc); end
    checks++; if (update_valid !== 1'b1 || update_pc !== 32'h700 || target_pc !== 32'h800) begin
      errors++; $display("[TB] FAIL wrong_target_enq got %h %h %h exp 1 700 800", update_valid, update_pc, target_pc); end
    update_ready = 1'b1;
    step();
    update_ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 16), 1'b1, 32'h2000 + 32'(i * 16), 1'b0, 32'h0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (drop_count !== ctr(1)) begin errors++; $display("[TB] FAIL t037_drop got %h exp %h", drop_count, ctr(1)); end
    step();
    checks++; if (update_valid !== 1'b1 || update_pc !== 32'h1000) begin errors++; $display("[TB] FAIL t037_hold got %h %h exp 1 1000", update_valid, update_pc); end
    update_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (update_valid !== 1'b1 || update_pc !== 32'h1000 + 32'(i * 16) || target_pc !== 32'h2000 + 32'(i * 16)) begin
        errors++; $display("[TB] FAIL t037_drain%0d got %h %h %h exp 1 %h %h", i, update_valid, update_pc, target_pc,
                           32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16));
      end
      step();
    end
    update_ready = 1'b0;
    checks++; if (update_valid !== 1'b0) begin errors++; $display("[TB] FAIL t037_empty got %h exp 0", update_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h3000 + 32'(i * 16), 1'b1, 32'h4000 + 32'(i * 16), 1'b0, 32'h0);
      step();
    end
    drive(1'b1, 32'h3F00, 1'b1, 32'h4F00, 1'b0, 32'h0);
    update_ready = 1'b1;
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    update_ready = 1'b0;
    checks++; if (drop_count !== ctr(1)) begin errors++; $display("[TB] FAIL t038_drop got %h exp %h", drop_count, ctr(1)); end
    update_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ep;
      logic [31:0] et;
      ep = (i == 3) ? 32'h3F00 : 32'h3000 + 32'((i + 1) * 16);
      et = (i == 3) ? 32'h4F00 : 32'h4000 + 32'((i + 1) * 16);
      checks++;
      if (update_valid !== 1'b1 || update_pc !== ep || target_pc !== et) begin
        errors++; $display("[TB] FAIL t038_drain%0d got %h %h %h exp 1 %h %h", i, update_valid, update_pc, target_pc, ep, et);
      end
      step();
    end
    update_ready = 1'b0;
    checks++; if (update_valid !== 1'b0) begin errors++; $display("[TB] FAIL t038_empty got %h exp 0", update_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA00 + 32'(i * 16), 1'b1, 32'hB00 + 32'(i * 16), 1'b0, 32'h0);
      step();
    end
    checks++; if (flush !== 1'b1 || update_valid !== 1'b1) begin errors++; $display("[TB] FAIL t039_setup got %h %h exp 1 1", flush, update_valid); end
    rst = 1'b0;
    #1;
    checks++; if (flush !== 1'b0 || redirect_pc !== 32'h0 || update_valid !== 1'b0 || update_pc !== 32'h0 || target_pc !== 32'h0) begin
      errors++; $display("[TB] FAIL t039_async got %h %h %h %h %h exp all 0", flush, redirect_pc, update_valid, update_pc, target_pc); end
    step();
    checks++; if (flush !== 1'b0 || update_valid !== 1'b0 || branch_count !== 32'h0 || drop_count !== 32'h0) begin
      errors++; $display("[TB] FAIL t039_held got %h %h %h %h exp all 0", flush, update_valid, branch_count, drop_count); end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    step();
    checks++; if (flush !== 1'b0 || update_valid !== 1'b0) begin errors++; $display("[TB] FAIL t039_release got %h %h exp 0 0", flush, update_valid); end
    drive(1'b1, 32'hC00, 1'b1, 32'hD00, 1'b0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'hD00 || update_pc !== 32'hC00) begin
      errors++; $display("[TB] FAIL t039_first_flush got %h %h %h exp 1 d00 c00", flush, redirect_pc, update_pc); end
    checks++; if (branch_count !== ctr(1) || mispredict_count !== ctr(1)) begin
      errors++; $display("[TB] FAIL t039_counters got %h %h exp %h %h", branch_count, mispredict_count, ctr(1), ctr(1)); end
  endtask

  initial begin
    test_reset();
    test_taken_mispredict();
    test_not_taken_mispredict();
    test_correct_taken();
    test_wrap_and_target();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PC/target width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, update-queue entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port ex_valid  input  1  resolved branch presented this cycle.
REQ-006 SHALL have port ex_pc  input  ADDR_WIDTH  PC of the resolved branch.
REQ-007 SHALL have port ex_taken  input  1  actual direction.
REQ-008 SHALL have port ex_target  input  ADDR_WIDTH  actual taken target.
REQ-009 SHALL have port ex_pred_taken  input  1  direction predicted at fetch.
REQ-010 SHALL have port ex_pred_target  input  ADDR_WIDTH  target predicted at fetch.
REQ-011 SHALL have port flush  output  1  mispredict redirect strobe.
REQ-012 SHALL have port redirect_pc  output  ADDR_WIDTH  correct next PC, valid with flush.
REQ-013 SHALL have port update_valid  output  1  BTB write request (queue head valid).
REQ-014 SHALL have port update_pc  output  ADDR_WIDTH  BTB write index/tag PC.
REQ-015 SHALL have port target_pc  output  ADDR_WIDTH  BTB write target.
REQ-016 SHALL have port update_ready  input  1  BTB accepts write this cycle.
REQ-017 SHALL have ports branch_count, mispredict_count, drop_count  output  32 each  performance counters.

Function
REQ-018 SHALL flag mispredict when ex_valid and (ex_taken != ex_pred_taken, or ex_taken and ex_pred_taken and ex_target != ex_pred_target).
REQ-019 SHALL register mispredict: flush high exactly one cycle, the cycle after the resolving ex_valid cycle; low otherwise.
REQ-020 SHALL drive redirect_pc registered alongside flush: ex_target if ex_taken, else ex_pc + 4 (modulo 2^ADDR_WIDTH, wrap silently); holds last value when flush low.
REQ-021 SHALL enqueue {ex_pc, ex_target} when ex_valid and ex_taken and (not ex_pred_taken or ex_target != ex_pred_target); no enqueue for not-taken or correctly predicted taken branches.
REQ-022 SHALL present queue head on update_pc/target_pc with update_valid = queue non-empty; outputs zero when empty.
REQ-023 SHALL pop head on the cycle update_valid and update_ready are both high; head stable while update_ready low.
REQ-024 SHALL make an entry pushed into an empty queue visible on update_valid the following cycle (no bypass).
REQ-025 SHALL, on push and pop in the same cycle, perform both, occupancy unchanged, including when full.
REQ-026 SHALL, on push while full without a same-cycle pop, drop the new entry, keep queue contents, increment drop_count.
REQ-027 SHALL use wrap-around read/write pointers with one extra bit to distinguish full from empty.
REQ-028 SHALL never back-pressure the execute stage; ex_valid is accepted every cycle.

Reset
REQ-029 SHALL on rst low, immediately: flush 0, redirect_pc 0, queue empty, update_valid 0, update_pc 0, target_pc 0, all counters 0.
REQ-030 SHALL discard in-flight mispredict and queued updates when reset asserts mid-operation; first flush possible the cycle after the first post-reset ex_valid.

Configuration
REQ-031 SHALL compile performance counters only when macro BRU_PERF_CTR_EN is defined.
REQ-032 SHALL, with BRU_PERF_CTR_EN: branch_count +1 per ex_valid, mispredict_count +1 per mispredict, drop_count +1 per drop, each saturating at 32'hFFFF_FFFF.
REQ-033 SHALL, without BRU_PERF_CTR_EN: counter ports tied to 0, no counter flops; all other behaviour identical.

Verification
REQ-034 SHALL test: ex_valid, pc=0x100, taken, target=0x200, pred not-taken -> next cycle flush=1, redirect_pc=0x200; queue gets {0x100,0x200}, update_valid=1 following cycle.
REQ-035 SHALL test: pc=0x300, not taken, pred taken to 0x400 -> flush=1, redirect_pc=0x304; no enqueue.
REQ-036 SHALL test: pc=0x500, taken 0x600, pred taken 0x600 -> flush stays 0, no enqueue, mispredict_count unchanged.
REQ-037 SHALL test: update_ready=0, 5 enqueuing branches with FIFO_DEPTH=4 -> first 4 retained in order, 5th dropped, drop_count=1; raise update_ready -> 4 writes on consecutive cycles, in order.
REQ-038 SHALL test: queue full, update_ready=1, enqueuing branch same cycle -> both pop and push, occupancy stays 4, drop_count unchanged.
REQ-039 SHALL test: rst pulsed low with 3 entries queued and flush pending -> all outputs 0 during reset, queue empty after release.
